// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
package program_loader_pkg;

    localparam int unsigned HDR_W          = 16;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_CNT_W     = HDR_W + 2;
    localparam int unsigned ASM_W          = 8 * (BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        RECV,
        CHK,
        FLUSH,
        BURST,
        RUN
    } state_t;

endpackage

// File: rtl/loader_buf.sv
// Program buffer: simple dual-port RAM, one write port, one synchronous-read port.
// The read address is registered here; data is valid the cycle after the address.
module loader_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr_q;

    // write port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // registered read address
    always_ff @(posedge clk) begin
        rd_addr_q <= rd_addr;
    end

    assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/program_loader.sv
// Framed byte stream -> buffered program -> contiguous instruction-load burst.
// Optional trailing checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned INSTR_W   = 32,
    parameter int unsigned BUF_DEPTH = 64,
    parameter int unsigned ADDR_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    output logic               s_ready,
    output logic               cpu_rst_n,
    output logic               ins_write,
    output logic [INSTR_W-1:0] instruction_in,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t                state, state_nxt;
    logic [HDR_W-1:0]      n_cnt, n_nxt;
    logic [BYTE_CNT_W-1:0] byte_cnt, byte_cnt_nxt;
    logic [ASM_W-1:0]      word_asm, word_nxt;
    logic [ADDR_W-1:0]     idx, idx_nxt;
    logic [ADDR_W-1:0]     rd_ptr, rd_ptr_nxt;
    logic [HDR_W-1:0]      burst_cnt, burst_nxt;
    logic                  discard, discard_nxt;
    logic                  s_ready_nxt, cpu_rst_n_nxt, ins_write_nxt;
    logic                  busy_nxt, done_nxt, err_nxt;
    logic [INSTR_W-1:0]    instr_nxt;
    logic                  accept_c;
    logic [HDR_W-1:0]      hdr_n_c;
    logic                  wr_en_c;
    logic [INSTR_W-1:0]    wr_data_c;
    logic [INSTR_W-1:0]    rd_data_c;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]            xor_acc, xor_nxt;
`endif

    assign accept_c  = s_valid && s_ready;
    assign hdr_n_c   = {s_data, n_cnt[7:0]};
    assign wr_data_c = INSTR_W'({s_data, word_asm});

    loader_buf #(
        .DATA_W (INSTR_W),
        .DEPTH  (BUF_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en_c),
        .wr_addr (idx),
        .wr_data (wr_data_c),
        .rd_addr (rd_ptr_nxt),
        .rd_data (rd_data_c)
    );

    // state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= HDR_LO;
            n_cnt          <= '0;
            byte_cnt       <= '0;
            word_asm       <= '0;
            idx            <= '0;
            rd_ptr         <= '0;
            burst_cnt      <= '0;
            discard        <= 1'b0;
            s_ready        <= 1'b1;
            cpu_rst_n      <= 1'b0;
            ins_write      <= 1'b0;
            instruction_in <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_acc        <= '0;
`endif
        end else begin
            state          <= state_nxt;
            n_cnt          <= n_nxt;
            byte_cnt       <= byte_cnt_nxt;
            word_asm       <= word_nxt;
            idx            <= idx_nxt;
            rd_ptr         <= rd_ptr_nxt;
            burst_cnt      <= burst_nxt;
            discard        <= discard_nxt;
            s_ready        <= s_ready_nxt;
            cpu_rst_n      <= cpu_rst_n_nxt;
            ins_write      <= ins_write_nxt;
            instruction_in <= instr_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            err            <= err_nxt;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_acc        <= xor_nxt;
`endif
        end
    end

    // next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        n_nxt         = n_cnt;
        byte_cnt_nxt  = byte_cnt;
        word_nxt      = word_asm;
        idx_nxt       = idx;
        rd_ptr_nxt    = rd_ptr;
        burst_nxt     = burst_cnt;
        discard_nxt   = discard;
        cpu_rst_n_nxt = cpu_rst_n;
        ins_write_nxt = ins_write;
        instr_nxt     = instruction_in;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        err_nxt       = err;
        wr_en_c       = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        xor_nxt       = xor_acc;
`endif

        case (state)
            HDR_LO, RUN: begin
                // first header byte; from RUN this also restarts the core
                if (accept_c) begin
                    n_nxt         = {8'h00, s_data};
                    err_nxt       = 1'b0;
                    busy_nxt      = 1'b1;
                    cpu_rst_n_nxt = 1'b0;
                    state_nxt     = HDR_HI;
                end
            end
            HDR_HI: begin
                if (accept_c) begin
                    n_nxt        = hdr_n_c;
                    byte_cnt_nxt = '0;
                    idx_nxt      = '0;
                    discard_nxt  = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    xor_nxt      = '0;
`endif
                    if (hdr_n_c == '0) begin
                        busy_nxt  = 1'b0;
                        state_nxt = HDR_LO;
                    end else if (hdr_n_c > HDR_W'(BUF_DEPTH)) begin
                        err_nxt     = 1'b1;
                        discard_nxt = 1'b1;
                        state_nxt   = RECV;
                    end else begin
                        state_nxt = RECV;
                    end
                end
            end
            RECV: begin
                if (accept_c) begin
                    byte_cnt_nxt = byte_cnt + BYTE_CNT_W'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    xor_nxt      = xor_acc ^ s_data;
`endif
                    case (byte_cnt[1:0])
                        2'd0: word_nxt[7:0]   = s_data;
                        2'd1: word_nxt[15:8]  = s_data;
                        2'd2: word_nxt[23:16] = s_data;
                        default: begin
                            wr_en_c = !discard;
                            idx_nxt = idx + ADDR_W'(1);
                        end
                    endcase
                    if (byte_cnt_nxt == {n_cnt, 2'b00}) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_nxt = CHK;
`else
                        if (discard) begin
                            busy_nxt  = 1'b0;
                            state_nxt = HDR_LO;
                        end else begin
                            rd_ptr_nxt = '0;
                            state_nxt  = FLUSH;
                        end
`endif
                    end
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept_c) begin
                    if (!discard && (s_data == xor_acc)) begin
                        rd_ptr_nxt = '0;
                        state_nxt  = FLUSH;
                    end else begin
                        err_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = HDR_LO;
                    end
                end
            end
`endif
            FLUSH: begin
                // buffer already presents word 0; start the burst
                cpu_rst_n_nxt = 1'b1;
                ins_write_nxt = 1'b1;
                instr_nxt     = rd_data_c;
                rd_ptr_nxt    = rd_ptr + ADDR_W'(1);
                burst_nxt     = '0;
                state_nxt     = BURST;
            end
            BURST: begin
                if (burst_cnt == n_cnt - HDR_W'(1)) begin
                    ins_write_nxt = 1'b0;
                    instr_nxt     = '0;
                    done_nxt      = 1'b1;
                    busy_nxt      = 1'b0;
                    state_nxt     = RUN;
                end else begin
                    instr_nxt  = rd_data_c;
                    rd_ptr_nxt = rd_ptr + ADDR_W'(1);
                    burst_nxt  = burst_cnt + HDR_W'(1);
                end
            end
            default: state_nxt = HDR_LO;
        endcase

        s_ready_nxt = !((state_nxt == FLUSH) || (state_nxt == BURST));
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader (default build, no checksum byte).
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        cpu_rst_n;
    logic        ins_write;
    logic [31:0] instruction_in;
    logic        busy;
    logic        done;
    logic        err;

    program_loader #(
        .INSTR_W   (32),
        .BUF_DEPTH (64),
        .ADDR_W    (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .cpu_rst_n      (cpu_rst_n),
        .ins_write      (ins_write),
        .instruction_in (instruction_in),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        logic        gap;
        logic [31:0] w0;
        logic [31:0] w1;
        int          exp_len;
        logic        exp_err;
        int          exp_done;
        logic        exp_cpu;
    } vec_t;

    vec_t vecs[6];

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] cap[$];
    int          dones;
    int          rises;
    int          bad_cpu;
    int          bad_align;
    logic        prev_iw  = 1'b0;
    logic        prev_cpu = 1'b0;

    // burst monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (ins_write) begin
            cap.push_back(instruction_in);
            if (!cpu_rst_n) bad_cpu++;
            if (!prev_iw) begin
                rises++;
                if (prev_cpu) bad_align++;
            end
        end
        if (done) dones++;
        prev_iw  = ins_write;
        prev_cpu = cpu_rst_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic clear_mon();
        cap.delete();
        dones     = 0;
        rises     = 0;
        bad_cpu   = 0;
        bad_align = 0;
    endtask

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        if (i == 0) return v.w0;
        if (i == 1) return v.w1;
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // drive one byte from a negedge; returns on the negedge after acceptance
    task automatic send_byte(input logic [7:0] b, input logic gap);
        int waited;
        if (gap) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        waited  = 0;
        while (s_ready !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 500) begin
            timeout_fail("byte_accept");
            s_valid = 1'b0;
            return;
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        logic [31:0] w;
        send_byte(v.n[7:0], v.gap);
        send_byte(v.n[15:8], v.gap);
        for (int i = 0; i < int'(v.n); i++) begin
            w = word_of(v, i);
            send_byte(w[7:0],   v.gap);
            send_byte(w[15:8],  v.gap);
            send_byte(w[23:16], v.gap);
            send_byte(w[31:24], v.gap);
        end
    endtask

    task automatic finish_frame();
        int waited = 0;
        while (busy !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 400) timeout_fail("busy_release");
        repeat (3) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        clear_mon();
        send_frame(v);
        finish_frame();
        check("burst_len", 32'(cap.size()), 32'(v.exp_len));
        for (int i = 0; i < cap.size() && i < v.exp_len; i++)
            check($sformatf("word%0d", i), cap[i], word_of(v, i));
        check("done_pulses", 32'(dones), 32'(v.exp_done));
        check("err", {31'd0, err}, {31'd0, v.exp_err});
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("cpu_rst_n", {31'd0, cpu_rst_n}, {31'd0, v.exp_cpu});
        check("burst_runs", 32'(rises), (v.exp_len > 0) ? 32'd1 : 32'd0);
        check("rst_during_write", 32'(bad_cpu), 32'd0);
        check("cpu_rise_align", 32'(bad_align), 32'd0);
    endtask

    initial begin
        int waited;

        //          n       gap   w0            w1            len err done cpu
        vecs[0] = '{16'd2,  1'b0, 32'h00A00093, 32'h00108133, 2,  1'b0, 1, 1'b1};
        vecs[1] = '{16'd2,  1'b1, 32'h00A00093, 32'h00108133, 2,  1'b0, 1, 1'b1};
        vecs[2] = '{16'd0,  1'b0, 32'h0,        32'h0,        0,  1'b0, 0, 1'b0};
        vecs[3] = '{16'd65, 1'b0, 32'hDEADBEEF, 32'h12345678, 0,  1'b1, 0, 1'b0};
        vecs[4] = '{16'd3,  1'b1, 32'h11111111, 32'h22222222, 3,  1'b0, 1, 1'b1};
        vecs[5] = '{16'd64, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 64, 1'b0, 1, 1'b1};

        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        clear_mon();
        repeat (3) @(negedge clk);
        check("rst_cpu_rst_n",   {31'd0, cpu_rst_n}, 32'd0);
        check("rst_ins_write",   {31'd0, ins_write}, 32'd0);
        check("rst_instruction", instruction_in,     32'd0);
        check("rst_s_ready",     {31'd0, s_ready},   32'd1);
        check("rst_err",         {31'd0, err},       32'd0);
        check("rst_busy",        {31'd0, busy},      32'd0);
        check("rst_done",        {31'd0, done},      32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // reload from RUN: next header byte offered while the burst still runs
        clear_mon();
        send_frame(vecs[0]);
        send_byte(8'h01, 1'b0);
        check("reload_prev_len",  32'(cap.size()), 32'd2);
        check("reload_prev_done", 32'(dones), 32'd1);
        check("reload_cpu_low",   {31'd0, cpu_rst_n}, 32'd0);
        check("reload_busy",      {31'd0, busy}, 32'd1);
        clear_mon();
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        finish_frame();
        check("reload_len",  32'(cap.size()), 32'd1);
        if (cap.size() > 0) check("reload_word", cap[0], 32'h00000013);
        check("reload_done", 32'(dones), 32'd1);
        check("reload_cpu",  {31'd0, cpu_rst_n}, 32'd1);

        // asynchronous reset in the middle of a burst
        clear_mon();
        send_frame(vecs[4]);
        waited = 0;
        while (ins_write !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) timeout_fail("burst_start");
        #2 rst = 1'b0;
        #1;
        check("arst_ins_write",   {31'd0, ins_write}, 32'd0);
        check("arst_cpu_rst_n",   {31'd0, cpu_rst_n}, 32'd0);
        check("arst_instruction", instruction_in,     32'd0);
        check("arst_busy",        {31'd0, busy},      32'd0);
        check("arst_s_ready",     {31'd0, s_ready},   32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Host-side instruction feeder for the single-cycle core's instruction-load port. It accepts a framed byte stream and buffers a complete program, then drives `ins_write`/`instruction_in` as one contiguous burst, one word per cycle. The burst must be contiguous because the core's write address advances on every cycle that `ins_write` is high. The block also owns the core's reset, so every load starts at instruction address 0.

## Interface
Parameters:
- `INSTR_W`, default 32: instruction word width.
- `BUF_DEPTH`, default 64: maximum words per program.
- `ADDR_W`, default 6: buffer index width, equal to log2(`BUF_DEPTH`).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `s_valid`  in  1  byte available
- `s_data`  in  8  stream byte
- `s_ready`  out  1  byte accepted when `s_valid && s_ready`
- `cpu_rst_n`  out  1  core reset, active-low; registered
- `ins_write`  out  1  core instruction-write enable; registered
- `instruction_in`  out  `INSTR_W`  instruction word to the core; registered
- `busy`  out  1  high from header start until the burst ends
- `done`  out  1  one-cycle pulse on the cycle after the last burst word
- `err`  out  1  sticky load error

## Operation
- **Frame format:** `N` as a 16-bit little-endian count, then N words of 4 bytes each, little-endian, then (only with the macro enabled) one checksum byte.
- **Reset values:** state HDR_LO; `s_ready`=1; `cpu_rst_n`=0; `ins_write`=0; `instruction_in`=0; `busy`=0; `done`=0; `err`=0; count and index registers 0.
- **State HDR_LO:**
  - Accepting a byte latches `N[7:0]`, clears `err`, sets `busy`, drives `cpu_rst_n` low and moves to HDR_HI.
- **State HDR_HI:**
  - Accepting a byte latches `N[15:8]`.
  - N=0: return to HDR_LO, `busy`=0, `cpu_rst_n` stays low.
  - N>`BUF_DEPTH`: set `err`, go to RECV in discard mode.
  - Otherwise go to RECV.
- **State RECV:**
  - Byte counter 0..3 assembles each word, with byte 0 at bits [7:0].
  - The fourth byte writes the word to `buf[idx]` and increments `idx`.
  - In discard mode bytes are consumed but nothing is written.
  - After 4·N bytes: go to CHK if the macro is enabled, else FLUSH. In discard mode go to HDR_LO instead, with `busy`=0.
- **State FLUSH (1 cycle):**
  - `s_ready`=0, `cpu_rst_n`=0, buffer read address preset to 0.
- **State BURST (N cycles):**
  - `cpu_rst_n`=1 and `ins_write`=1.
  - In burst cycle k (k=0..N-1), `instruction_in`=`buf[k]`.
  - `s_ready`=0.
- **State RUN:**
  - Entered on the cycle after burst cycle N-1: `ins_write`=0, `instruction_in`=0, `done`=1 for one cycle, `busy`=0, `cpu_rst_n` stays 1.
  - `s_ready`=1. An accepted byte is treated as `N[7:0]` of a new frame: `cpu_rst_n` drops to 0 registered on the next edge, and the state moves to HDR_HI.
- **Arithmetic:**
  - `N` is unsigned 16-bit.
  - The RECV byte count is 18-bit, sized for 4·65535.
  - `idx` wraps only in discard mode, where it is unused.
- **`err`:** stays set until the next HDR_LO byte is accepted. The core is held in reset while any load fails.

## Timing
- The handshake is valid/ready, with at most one byte per cycle. `s_ready` is a registered function of state. `s_valid` may be high while `s_ready` is low; the byte is not consumed.
- Latency from the last payload byte to the first `ins_write`:
  - 2 cycles without the macro (FLUSH, then BURST).
  - 3 cycles with it: the checksum byte must arrive first, and FLUSH/BURST follow it at the same 2-cycle spacing.
- `ins_write` is high for exactly N consecutive cycles, with no gaps. `cpu_rst_n` rises on the same edge that `ins_write` first rises.
- The buffer is synchronous-read. The read address runs one cycle ahead of the burst index so that the `instruction_in` register is loaded from the buffer on each edge.
- An asynchronous `rst` at any point, including mid-burst, returns all outputs to their reset values immediately. A partially received frame is discarded.

## Configuration
- **`PROGRAM_LOADER_CHECKSUM_EN` defined:** state CHK accepts one byte and compares it with the XOR of all 4·N payload bytes.
  - Match: go to FLUSH.
  - Mismatch: set `err`, go to HDR_LO with `busy`=0; no burst occurs.
  - In discard mode the checksum byte is still consumed.
- **Undefined:** there is no CHK state, no checksum byte is expected, and there is no XOR accumulator.

## Structure
- **Package `program_loader_pkg`:**
  - State enum: HDR_LO, HDR_HI, RECV, CHK, FLUSH, BURST, RUN.
  - Header width constant (16).
  - Bytes-per-word constant (4).
- **Sub-module `loader_buf`:** simple dual-port RAM with `BUF_DEPTH`×`INSTR_W` entries, one write port and one synchronous-read port, no reset on the array.

## Test plan
- **Reset check:** hold `rst` low -> `cpu_rst_n`=0, `ins_write`=0, `instruction_in`=0, `s_ready`=1, `err`=0.
- **Normal load:** frame N=2, words 0x00A00093 and 0x00108133 -> `ins_write` high exactly 2 cycles presenting those words in order, `cpu_rst_n` rises with the burst, `done` pulses once.
- **Gappy stream:** as above but with random `s_valid` gaps and `s_ready` stalls -> identical burst, no byte lost or duplicated.
- **Zero and overflow counts:**
  - N=0 -> no burst, `busy` returns to 0.
  - N=65 with `BUF_DEPTH`=64 -> all 260 payload bytes consumed, `err`=1, no `ins_write`, `cpu_rst_n` held 0.
- **Reload from RUN:** new frame N=1 with word 0x00000013 -> `cpu_rst_n` falls after the first byte, one-cycle burst of 0x00000013.
- **Checksum (with `PROGRAM_LOADER_CHECKSUM_EN`):** correct XOR -> burst occurs; XOR^0x01 -> `err`=1, no burst. Separately, async `rst` pulse mid-burst -> `ins_write` drops immediately, state HDR_LO.
